ll_boundary_splitter: RTL and testbench
=======================================

Name: ll_boundary_splitter

Overview:
- Parametrised successor of the LocalLink receive boundary stage. Accepts one LocalLink byte/word stream and splits each frame into a header stream (first HDR_LEN beats) and a content stream (remaining beats).
- Tags every frame with a content ID (CID).
- Adds per-stream backpressure, max-length truncation, protocol-error recovery and statistics counters.
- Sits between the MAC LocalLink receive interface and the header parser / content pre-filter.

Parameters:
- DW, 8, data width of LocalLink and both output streams, in bits.
- HDR_LEN, 54, number of beats routed to the header stream; range 1..1023.
- MAX_LEN, 1518, maximum frame length in beats; beats past it are dropped; must be > HDR_LEN.
- CID_W, 9, content-ID width; the ID wraps modulo 2^CID_W.
- CNT_W, 16, width of the statistics counters; counters saturate at all-ones.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rx_ll_data_in  in  DW  LocalLink data
- rx_ll_sof_in_n  in  1  start of frame, active low
- rx_ll_eof_in_n  in  1  end of frame, active low
- rx_ll_src_rdy_n  in  1  source ready, active low
- rx_ll_dst_rdy_n  out  1  destination ready, active low
- HStop  in  1  header consumer stall
- CStop  in  1  content consumer stall
- oHead  out  DW  header data
- HSod, HEn, HEod  out  1  header start, valid and end strobes
- oCont  out  DW  content data
- CSod, CEn, CEod  out  1  content start, valid and end strobes
- o_cid  out  CID_W  CID of the current frame; held between frames
- o_cid_vld  out  1  one-cycle pulse when a new CID is issued
- o_pkt_cnt  out  CNT_W  frames accepted
- o_err_cnt  out  CNT_W  frames aborted or truncated

Behaviour:
- Transfer rule: a beat transfers when rx_ll_src_rdy_n=0 and rx_ll_dst_rdy_n=0.
- Destination ready (combinational from state):
  - rx_ll_dst_rdy_n = HStop in IDLE/HEAD.
  - rx_ll_dst_rdy_n = CStop in CONT.
  - rx_ll_dst_rdy_n = 0 in DROP.
  - rx_ll_dst_rdy_n = 1 while rst is asserted.
- Outputs: all stream outputs are registered, with 1-cycle latency from transfer to strobe. Strobes are single-cycle per beat; data is held when not valid.
- Reset: all strobes 0, data 0, o_cid = all-ones (so the first frame gets CID 0), counters 0, state IDLE, beat counter 0.
- Beat counter: width clog2(MAX_LEN+1); cleared at every SOF transfer.
- FSM IDLE:
  - Non-SOF beats are accepted and discarded, with no count.
  - SOF beat: emit HSod=HEn=1, increment the CID, pulse o_cid_vld, go to HEAD.
  - If EOF arrives on the same beat: also emit HEod, increment pkt_cnt, stay in IDLE.
  - If HDR_LEN=1 and no EOF: emit HEod, go to CONT.
- FSM HEAD:
  - Each beat emits HEn.
  - Beat index HDR_LEN-1 emits HEod and moves to CONT.
  - EOF on an earlier beat (short frame) emits HEod, increments pkt_cnt and returns to IDLE; no content strobes are produced.
- FSM CONT:
  - The first beat emits CSod+CEn; later beats emit CEn.
  - EOF emits CEod, increments pkt_cnt and goes to IDLE.
  - Beat index MAX_LEN-1 without EOF: emit CEod, increment err_cnt, go to DROP.
- FSM DROP: discard beats until EOF transfers, then go to IDLE. No output strobes are produced.
- SOF received while in HEAD or CONT (protocol error):
  - On the next cycle, output a bare end marker (HEod or CEod with HEn/CEn=0) on the open stream.
  - Increment err_cnt; do not increment pkt_cnt.
  - Discard the SOF beat and go to DROP if it has no EOF, or IDLE if SOF and EOF coincide.
- An EOF on a beat that is also the HDR_LEN-1 beat closes the header only; the frame has no content, and pkt_cnt increments.
- src_rdy_n deasserted mid-frame: state and counters hold, and no strobes are emitted.
- Reset asserted mid-frame: all outputs clear immediately. The partial frame is lost without end markers, and downstream must reset too.
- Counters and CID:
  - Counters saturate at all-ones rather than wrapping.
  - CID increments modulo 2^CID_W, issued on SOF accept in IDLE.
  - pkt_cnt and err_cnt increments on the same cycle are both applied.

Test Plan:
- HDR_LEN=4, 10-beat frame with data 0..9 and no stalls:
  - Header strobes: HSod on data 0, HEn for 0..3, HEod on 3.
  - Content strobes: CSod on 4, CEn for 4..9, CEod on 9.
  - o_cid=0 with an o_cid_vld pulse; pkt_cnt=1.
- 3-beat frame with HDR_LEN=4: HEod on beat 2, no content strobes, pkt_cnt increments; a second frame gets o_cid=1.
- HStop held high for 5 cycles mid-header: rx_ll_dst_rdy_n=1 for those cycles, no HEn, data order is preserved after release; same check for CStop during content.
- MAX_LEN=8 with a 12-beat frame: CEod on beat 7, beats 8..11 are accepted and discarded, err_cnt=1, pkt_cnt unchanged.
- SOF at beat 6 of an open frame: a bare CEod appears the next cycle, err_cnt increments, the rest is dropped until EOF, and the following frame splits normally.
- CID wrap and reset:
  - With CID_W=2, five frames give CIDs 0,1,2,3,0.
  - Asserting rst mid-content clears all strobes and counters asynchronously, and o_cid returns to all-ones.

Source files
------------

// File: rtl/ll_boundary_splitter.sv
// ll_boundary_splitter: splits LocalLink frames into header/content streams with CID tagging, truncation and stats
module ll_boundary_splitter #(
    parameter int DW      = 8,
    parameter int HDR_LEN = 54,
    parameter int MAX_LEN = 1518,
    parameter int CID_W   = 9,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    rx_ll_data_in,
    input  logic             rx_ll_sof_in_n,
    input  logic             rx_ll_eof_in_n,
    input  logic             rx_ll_src_rdy_n,
    output logic             rx_ll_dst_rdy_n,
    input  logic             HStop,
    input  logic             CStop,
    output logic [DW-1:0]    oHead,
    output logic             HSod,
    output logic             HEn,
    output logic             HEod,
    output logic [DW-1:0]    oCont,
    output logic             CSod,
    output logic             CEn,
    output logic             CEod,
    output logic [CID_W-1:0] o_cid,
    output logic             o_cid_vld,
    output logic [CNT_W-1:0] o_pkt_cnt,
    output logic [CNT_W-1:0] o_err_cnt
);
    localparam int BW = $clog2(MAX_LEN + 1);
    typedef enum logic [1:0] {IDLE, HEAD, CONT, DROP} state_t;
    state_t state_q, state_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [DW-1:0] ohead_q, ohead_d, ocont_q, ocont_d;
    logic hsod_q, hsod_d, hen_q, hen_d, heod_q, heod_d;
    logic csod_q, csod_d, cen_q, cen_d, ceod_q, ceod_d;
    logic [CID_W-1:0] cid_q, cid_d;
    logic cid_vld_q, cid_vld_d;
    logic [CNT_W-1:0] pkt_q, pkt_d, err_q, err_d;
    logic xfer, sof, eof, last_hdr, last_max, pkt_inc, err_inc;

    assign rx_ll_dst_rdy_n = rst | (state_q == CONT ? CStop : state_q == DROP ? 1'b0 : HStop);

    always_comb begin
        xfer      = !rx_ll_src_rdy_n && !rx_ll_dst_rdy_n;
        sof       = !rx_ll_sof_in_n;
        eof       = !rx_ll_eof_in_n;
        last_hdr  = bcnt_q == BW'(HDR_LEN - 1);
        last_max  = bcnt_q == BW'(MAX_LEN - 1);
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        ohead_d   = ohead_q;
        ocont_d   = ocont_q;
        hsod_d    = 1'b0;
        hen_d     = 1'b0;
        heod_d    = 1'b0;
        csod_d    = 1'b0;
        cen_d     = 1'b0;
        ceod_d    = 1'b0;
        cid_d     = cid_q;
        cid_vld_d = 1'b0;
        pkt_inc   = 1'b0;
        err_inc   = 1'b0;
        if (xfer) begin
            case (state_q)
                IDLE: if (sof) begin
                    hsod_d    = 1'b1;
                    hen_d     = 1'b1;
                    ohead_d   = rx_ll_data_in;
                    cid_d     = cid_q + 1'b1;
                    cid_vld_d = 1'b1;
                    bcnt_d    = BW'(1);
                    heod_d    = eof || HDR_LEN == 1;
                    pkt_inc   = eof;
                    state_d   = eof ? IDLE : HDR_LEN == 1 ? CONT : HEAD;
                end
                HEAD: if (sof) begin
                    heod_d  = 1'b1;
                    err_inc = 1'b1;
                    bcnt_d  = '0;
                    state_d = eof ? IDLE : DROP;
                end else begin
                    hen_d   = 1'b1;
                    ohead_d = rx_ll_data_in;
                    bcnt_d  = bcnt_q + 1'b1;
                    heod_d  = eof || last_hdr;
                    pkt_inc = eof;
                    state_d = eof ? IDLE : last_hdr ? CONT : HEAD;
                end
                CONT: if (sof) begin
                    ceod_d  = 1'b1;
                    err_inc = 1'b1;
                    bcnt_d  = '0;
                    state_d = eof ? IDLE : DROP;
                end else begin
                    cen_d   = 1'b1;
                    ocont_d = rx_ll_data_in;
                    csod_d  = bcnt_q == BW'(HDR_LEN);
                    bcnt_d  = bcnt_q + 1'b1;
                    ceod_d  = eof || last_max;
                    pkt_inc = eof;
                    err_inc = !eof && last_max;
                    state_d = eof ? IDLE : last_max ? DROP : CONT;
                end
                default: state_d = eof ? IDLE : DROP;
            endcase
        end
        pkt_d = (pkt_inc && !(&pkt_q)) ? pkt_q + 1'b1 : pkt_q;
        err_d = (err_inc && !(&err_q)) ? err_q + 1'b1 : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bcnt_q    <= '0;
            ohead_q   <= '0;
            ocont_q   <= '0;
            hsod_q    <= 1'b0;
            hen_q     <= 1'b0;
            heod_q    <= 1'b0;
            csod_q    <= 1'b0;
            cen_q     <= 1'b0;
            ceod_q    <= 1'b0;
            cid_q     <= '1;
            cid_vld_q <= 1'b0;
            pkt_q     <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            ohead_q   <= ohead_d;
            ocont_q   <= ocont_d;
            hsod_q    <= hsod_d;
            hen_q     <= hen_d;
            heod_q    <= heod_d;
            csod_q    <= csod_d;
            cen_q     <= cen_d;
            ceod_q    <= ceod_d;
            cid_q     <= cid_d;
            cid_vld_q <= cid_vld_d;
            pkt_q     <= pkt_d;
            err_q     <= err_d;
        end
    end

    assign oHead     = ohead_q;
    assign HSod      = hsod_q;
    assign HEn       = hen_q;
    assign HEod      = heod_q;
    assign oCont     = ocont_q;
    assign CSod      = csod_q;
    assign CEn       = cen_q;
    assign CEod      = ceod_q;
    assign o_cid     = cid_q;
    assign o_cid_vld = cid_vld_q;
    assign o_pkt_cnt = pkt_q;
    assign o_err_cnt = err_q;
endmodule

// File: tb/tb_ll_boundary_splitter.sv
// tb_ll_boundary_splitter: directed bench, instance a (MAX_LEN=16, CID_W=9) and b (MAX_LEN=8, CID_W=2), both HDR_LEN=4
module tb_ll_boundary_splitter;
    logic clk = 1'b0, rst = 1'b0;
    logic [7:0] data = '0;
    logic sof_n = 1'b1, eof_n = 1'b1, src_n = 1'b1, hstop = 1'b0, cstop = 1'b0;
    logic dst_a, dst_b;
    logic [7:0] ohead_a, ocont_a, ohead_b, ocont_b;
    logic hsod_a, hen_a, heod_a, csod_a, cen_a, ceod_a;
    logic hsod_b, hen_b, heod_b, csod_b, cen_b, ceod_b;
    logic [8:0] cid_a;
    logic [1:0] cid_b;
    logic vld_a, vld_b;
    logic [15:0] pkt_a, err_a, pkt_b, err_b;
    logic [10:0] ha[$], ca[$], cb[$];
    logic [10:0] exp_e;
    int n_vec = 0, n_err = 0, nvld_a = 0;
    int hs, cs, bs, nv;

    always #5 clk = ~clk;

    ll_boundary_splitter #(.DW(8), .HDR_LEN(4), .MAX_LEN(16), .CID_W(9), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .rx_ll_data_in(data), .rx_ll_sof_in_n(sof_n), .rx_ll_eof_in_n(eof_n),
        .rx_ll_src_rdy_n(src_n), .rx_ll_dst_rdy_n(dst_a), .HStop(hstop), .CStop(cstop),
        .oHead(ohead_a), .HSod(hsod_a), .HEn(hen_a), .HEod(heod_a),
        .oCont(ocont_a), .CSod(csod_a), .CEn(cen_a), .CEod(ceod_a),
        .o_cid(cid_a), .o_cid_vld(vld_a), .o_pkt_cnt(pkt_a), .o_err_cnt(err_a));

    ll_boundary_splitter #(.DW(8), .HDR_LEN(4), .MAX_LEN(8), .CID_W(2), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .rx_ll_data_in(data), .rx_ll_sof_in_n(sof_n), .rx_ll_eof_in_n(eof_n),
        .rx_ll_src_rdy_n(src_n), .rx_ll_dst_rdy_n(dst_b), .HStop(hstop), .CStop(cstop),
        .oHead(ohead_b), .HSod(hsod_b), .HEn(hen_b), .HEod(heod_b),
        .oCont(ocont_b), .CSod(csod_b), .CEn(cen_b), .CEod(ceod_b),
        .o_cid(cid_b), .o_cid_vld(vld_b), .o_pkt_cnt(pkt_b), .o_err_cnt(err_b));

    always @(negedge clk) begin
        if (hen_a || heod_a) ha.push_back({hsod_a, hen_a, heod_a, ohead_a});
        if (cen_a || ceod_a) ca.push_back({csod_a, cen_a, ceod_a, ocont_a});
        if (cen_b || ceod_b) cb.push_back({csod_b, cen_b, ceod_b, ocont_b});
        if (vld_a) nvld_a = nvld_a + 1;
    end

    task automatic send(input logic [7:0] d, input logic s, input logic e);
        data = d; sof_n = ~s; eof_n = ~e; src_n = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        src_n = 1'b1; sof_n = 1'b1; eof_n = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) send(base + 8'(i), i == 0, i == n - 1);
        idle(2);
    endtask

    task automatic do_reset();
        hstop = 1'b0; cstop = 1'b0;
        idle(0);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (dst_a !== 1'b1) begin n_err++; $display("FAIL rst_dst got %b exp 1", dst_a); end
        n_vec++; if ({hsod_a, hen_a, heod_a, csod_a, cen_a, ceod_a, vld_a} !== 7'b0) begin n_err++; $display("FAIL rst_strobes got %b exp 0", {hsod_a, hen_a, heod_a, csod_a, cen_a, ceod_a, vld_a}); end
        n_vec++; if ({ohead_a, ocont_a} !== 16'h0) begin n_err++; $display("FAIL rst_data got %h exp 0000", {ohead_a, ocont_a}); end
        n_vec++; if (cid_a !== 9'h1FF || cid_b !== 2'b11) begin n_err++; $display("FAIL rst_cid got %h/%h exp 1ff/3", cid_a, cid_b); end
        n_vec++; if ({pkt_a, err_a} !== 32'h0) begin n_err++; $display("FAIL rst_cnt got %h exp 0", {pkt_a, err_a}); end
        @(negedge clk); rst = 1'b0; #1;
        n_vec++; if (dst_a !== 1'b0) begin n_err++; $display("FAIL rst_release_dst got %b exp 0", dst_a); end
    endtask

    task automatic test_split();
        do_reset(); rst = 1'b0;
        hs = ha.size(); cs = ca.size(); nv = nvld_a;
        frame(10, 8'h00);
        n_vec++; if (ha.size() - hs !== 4) begin n_err++; $display("FAIL split_hcount got %0d exp 4", ha.size() - hs); end
        n_vec++; if (ca.size() - cs !== 6) begin n_err++; $display("FAIL split_ccount got %0d exp 6", ca.size() - cs); end
        for (int i = 0; i < 4 && hs + i < ha.size(); i++) begin
            exp_e = {1'(i == 0), 1'b1, 1'(i == 3), 8'(i)};
            n_vec++; if (ha[hs + i] !== exp_e) begin n_err++; $display("FAIL split_h%0d got %h exp %h", i, ha[hs + i], exp_e); end
        end
        for (int i = 0; i < 6 && cs + i < ca.size(); i++) begin
            exp_e = {1'(i == 0), 1'b1, 1'(i == 5), 8'(i + 4)};
            n_vec++; if (ca[cs + i] !== exp_e) begin n_err++; $display("FAIL split_c%0d got %h exp %h", i, ca[cs + i], exp_e); end
        end
        n_vec++; if (cid_a !== 9'd0 || nvld_a - nv !== 1) begin n_err++; $display("FAIL split_cid got %h pulses %0d exp 0 pulses 1", cid_a, nvld_a - nv); end
        n_vec++; if (pkt_a !== 16'd1 || err_a !== 16'd0) begin n_err++; $display("FAIL split_cnt got %0d/%0d exp 1/0", pkt_a, err_a); end
    endtask

    task automatic test_short();
        do_reset(); rst = 1'b0;
        hs = ha.size(); cs = ca.size();
        frame(3, 8'h20);
        n_vec++; if (ha.size() - hs !== 3 || ca.size() - cs !== 0) begin n_err++; $display("FAIL short_count got %0d/%0d exp 3/0", ha.size() - hs, ca.size() - cs); end
        if (ha.size() - hs >= 3) begin
            n_vec++; if (ha[hs + 2] !== {3'b011, 8'h22}) begin n_err++; $display("FAIL short_heod got %h exp 322", ha[hs + 2]); end
        end
        n_vec++; if (pkt_a !== 16'd1 || cid_a !== 9'd0) begin n_err++; $display("FAIL short_cnt got %0d cid %0d exp 1 cid 0", pkt_a, cid_a); end
        frame(5, 8'h30);
        n_vec++; if (cid_a !== 9'd1 || pkt_a !== 16'd2) begin n_err++; $display("FAIL short_second got cid %0d pkt %0d exp 1/2", cid_a, pkt_a); end
        n_vec++; if (ca.size() - cs !== 1) begin n_err++; $display("FAIL short_ccount got %0d exp 1", ca.size() - cs); end
        else begin
            n_vec++; if (ca[cs] !== {3'b111, 8'h34}) begin n_err++; $display("FAIL short_onecont got %h exp 734", ca[cs]); end
        end
    endtask

    task automatic test_stall();
        do_reset(); rst = 1'b0;
        hs = ha.size(); cs = ca.size();
        send(8'h50, 1'b1, 1'b0);
        send(8'h51, 1'b0, 1'b0);
        data = 8'h52; sof_n = 1'b1; hstop = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++; if (dst_a !== 1'b1) begin n_err++; $display("FAIL hstop_dst%0d got %b exp 1", k, dst_a); end
            @(posedge clk); #1;
        end
        n_vec++; if (ha.size() - hs !== 2) begin n_err++; $display("FAIL hstop_hen got %0d exp 2", ha.size() - hs); end
        hstop = 1'b0;
        for (int i = 2; i < 6; i++) send(8'h50 + 8'(i), 1'b0, 1'b0);
        data = 8'h56; cstop = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++; if (dst_a !== 1'b1) begin n_err++; $display("FAIL cstop_dst%0d got %b exp 1", k, dst_a); end
            @(posedge clk); #1;
        end
        n_vec++; if (ca.size() - cs !== 2) begin n_err++; $display("FAIL cstop_cen got %0d exp 2", ca.size() - cs); end
        cstop = 1'b0;
        for (int i = 6; i < 10; i++) send(8'h50 + 8'(i), 1'b0, i == 9);
        idle(2);
        n_vec++; if (ha.size() - hs !== 4 || ca.size() - cs !== 6) begin n_err++; $display("FAIL stall_count got %0d/%0d exp 4/6", ha.size() - hs, ca.size() - cs); end
        for (int i = 0; i < 4 && hs + i < ha.size(); i++) begin
            n_vec++; if (ha[hs + i][7:0] !== 8'h50 + 8'(i)) begin n_err++; $display("FAIL stall_hdata%0d got %h exp %h", i, ha[hs + i][7:0], 8'h50 + 8'(i)); end
        end
        for (int i = 0; i < 6 && cs + i < ca.size(); i++) begin
            n_vec++; if (ca[cs + i][7:0] !== 8'h54 + 8'(i)) begin n_err++; $display("FAIL stall_cdata%0d got %h exp %h", i, ca[cs + i][7:0], 8'h54 + 8'(i)); end
        end
    endtask

    task automatic test_trunc();
        do_reset(); rst = 1'b0;
        bs = cb.size();
        frame(12, 8'h40);
        n_vec++; if (cb.size() - bs !== 4) begin n_err++; $display("FAIL trunc_count got %0d exp 4", cb.size() - bs); end
        else begin
            n_vec++; if (cb[bs] !== {3'b110, 8'h44}) begin n_err++; $display("FAIL trunc_csod got %h exp 644", cb[bs]); end
            n_vec++; if (cb[bs + 3] !== {3'b011, 8'h47}) begin n_err++; $display("FAIL trunc_ceod got %h exp 347", cb[bs + 3]); end
        end
        n_vec++; if (err_b !== 16'd1 || pkt_b !== 16'd0) begin n_err++; $display("FAIL trunc_cnt got err %0d pkt %0d exp 1/0", err_b, pkt_b); end
        n_vec++; if (pkt_a !== 16'd1 || err_a !== 16'd0) begin n_err++; $display("FAIL trunc_long_ok got pkt %0d err %0d exp 1/0", pkt_a, err_a); end
        frame(6, 8'h70);
        n_vec++; if (pkt_b !== 16'd1 || cb.size() - bs !== 6) begin n_err++; $display("FAIL trunc_recover got pkt %0d cnt %0d exp 1/6", pkt_b, cb.size() - bs); end
    endtask

    task automatic test_proto();
        do_reset(); rst = 1'b0;
        hs = ha.size(); cs = ca.size();
        for (int i = 0; i < 6; i++) send(8'(i), i == 0, 1'b0);
        send(8'h66, 1'b1, 1'b0);
        send(8'h07, 1'b0, 1'b0);
        send(8'h08, 1'b0, 1'b0);
        send(8'h09, 1'b0, 1'b1);
        idle(2);
        n_vec++; if (ca.size() - cs !== 3) begin n_err++; $display("FAIL proto_ccount got %0d exp 3", ca.size() - cs); end
        else begin
            n_vec++; if (ca[cs + 2] !== {3'b001, 8'h05}) begin n_err++; $display("FAIL proto_bare got %h exp 105", ca[cs + 2]); end
        end
        n_vec++; if (err_a !== 16'd1 || pkt_a !== 16'd0) begin n_err++; $display("FAIL proto_cnt got err %0d pkt %0d exp 1/0", err_a, pkt_a); end
        frame(6, 8'h80);
        n_vec++; if (ha.size() - hs !== 8 || ca.size() - cs !== 5) begin n_err++; $display("FAIL proto_next_count got %0d/%0d exp 8/5", ha.size() - hs, ca.size() - cs); end
        else begin
            n_vec++; if (ha[hs + 4] !== {3'b110, 8'h80}) begin n_err++; $display("FAIL proto_next_hsod got %h exp 680", ha[hs + 4]); end
            n_vec++; if (ca[cs + 4] !== {3'b011, 8'h85}) begin n_err++; $display("FAIL proto_next_ceod got %h exp 385", ca[cs + 4]); end
        end
        n_vec++; if (cid_a !== 9'd1 || pkt_a !== 16'd1) begin n_err++; $display("FAIL proto_next_cid got cid %0d pkt %0d exp 1/1", cid_a, pkt_a); end
    endtask

    task automatic test_cid_wrap();
        do_reset(); rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            frame(2, 8'(k));
            n_vec++; if (cid_b !== 2'(k)) begin n_err++; $display("FAIL cid_wrap%0d got %0d exp %0d", k, cid_b, 2'(k)); end
        end
        n_vec++; if (pkt_b !== 16'd5) begin n_err++; $display("FAIL cid_wrap_pkt got %0d exp 5", pkt_b); end
    endtask

    task automatic test_rst_mid();
        do_reset(); rst = 1'b0;
        frame(6, 8'h10);
        for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i), i == 0, 1'b0);
        n_vec++; if (cen_a !== 1'b1 || pkt_a !== 16'd1) begin n_err++; $display("FAIL rstmid_pre got cen %b pkt %0d exp 1/1", cen_a, pkt_a); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if ({cen_a, csod_a, ceod_a, hen_a, heod_a} !== 5'b0 || ocont_a !== 8'h00) begin n_err++; $display("FAIL rstmid_strobes got %b/%h exp 0/00", {cen_a, csod_a, ceod_a, hen_a, heod_a}, ocont_a); end
        n_vec++; if (pkt_a !== 16'd0 || cid_a !== 9'h1FF || dst_a !== 1'b1) begin n_err++; $display("FAIL rstmid_state got pkt %0d cid %h dst %b exp 0/1ff/1", pkt_a, cid_a, dst_a); end
        idle(1);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        test_reset();
        test_split();
        test_short();
        test_stall();
        test_trunc();
        test_proto();
        test_cid_wrap();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
